dts_search_scheduler: RTL and testbench

- Sequences a pool of K difference-triangle-set search workers over a partitioned search space of JOBS job indices (e.g. fixed first-block prefixes).
- Dispatches jobs round-robin to idle workers, retires completions and captures the first found DTS result (res, n*(M+1) bits).
- Reports overall completion.
- Sits between the top-level host/test interface and the replicated worker array.

---
 rtl/dts_search_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_dts_search_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dts_search_scheduler.sv
// Round-robin job scheduler for a pool of K difference-triangle-set search workers.
// Dispatches job indices, retires completions and keeps the first found result.
module dts_search_scheduler #(
    parameter int N             = 3,
    parameter int M             = 19,
    parameter int K             = 4,
    parameter int KW            = 2,
    parameter int JOBS          = 16,
    parameter int JW            = 4,
    parameter int STOP_ON_FOUND = 1,
    localparam int RW           = N * (M + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic [K-1:0]    wk_go,
    output logic [JW-1:0]   wk_job,
    input  logic [K-1:0]    wk_done,
    input  logic [K-1:0]    wk_found,
    input  logic [K*RW-1:0] wk_res,
    output logic            res_valid,
    output logic [RW-1:0]   res,
    output logic [JW-1:0]   res_job,
    output logic            found,
    output logic [JW:0]     jobs_done,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [K-1:0]    wbusy_q, wbusy_d;
    logic [JW-1:0]   job_of_q [K];
    logic [JW-1:0]   job_of_d [K];
    logic [JW:0]     next_job_q, next_job_d;
    logic [KW-1:0]   rr_q, rr_d;
    logic [K-1:0]    go_q, go_d;
    logic [JW-1:0]   wjob_q, wjob_d;
    logic            rv_q, rv_d;
    logic [RW-1:0]   res_q, res_d;
    logic [JW-1:0]   res_job_q, res_job_d;
    logic            found_q, found_d;
    logic [JW:0]     jdone_q, jdone_d;

    logic            entry, run_active, ret_hit, cap, pick_hit, disp_en, go_ok;
    logic [K-1:0]    base_busy, cand;
    logic [JW:0]     base_next;
    logic [KW-1:0]   base_rr, ret_w, pick_w, scan_idx;
    logic [RW-1:0]   res_slice [K];

    for (genvar g = 0; g < K; g++) begin : g_slice
        assign res_slice[g] = wk_res[g*RW +: RW];
    end

    always_comb begin
        state_d    = state_q;
        wbusy_d    = wbusy_q;
        job_of_d   = job_of_q;
        next_job_d = next_job_q;
        rr_d       = rr_q;
        go_d       = '0;
        wjob_d     = '0;
        rv_d       = 1'b0;
        res_d      = res_q;
        res_job_d  = res_job_q;
        found_d    = found_q;
        jdone_d    = jdone_q;
        scan_idx   = '0;

        // Run entry dispatches job 0 in the same edge that leaves IDLE/FINISH,
        // working from the freshly cleared run state.
        entry      = start && (state_q == S_IDLE || state_q == S_FINISH);
        run_active = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
        base_busy  = entry ? '0 : wbusy_q;
        base_next  = entry ? '0 : next_job_q;
        base_rr    = entry ? '0 : rr_q;

        // A worker whose go pulse is still visible has not yet dropped its
        // stale done from the previous job, so it cannot be retired yet.
        cand    = run_active ? (wbusy_q & wk_done & ~go_q) : '0;
        ret_hit = 1'b0;
        ret_w   = '0;
        for (int w = K - 1; w >= 0; w--) begin
            if (cand[KW'(w)]) begin
                ret_hit = 1'b1;
                ret_w   = KW'(w);
            end
        end
        cap = ret_hit && wk_found[ret_w] && !found_q;

        pick_hit = 1'b0;
        pick_w   = '0;
        for (int i = K - 1; i >= 0; i--) begin
            scan_idx = KW'((int'(base_rr) + i) % K);
            if (!base_busy[scan_idx]) begin
                pick_hit = 1'b1;
                pick_w   = scan_idx;
            end
        end
        disp_en = entry ||
                  (state_q == S_DISPATCH && !(STOP_ON_FOUND != 0 && (found_q || cap)));
        go_ok   = disp_en && pick_hit && (base_next < (JW+1)'(JOBS));

        if (entry) begin
            wbusy_d    = '0;
            next_job_d = '0;
            rr_d       = '0;
            res_d      = '0;
            res_job_d  = '0;
            found_d    = 1'b0;
            jdone_d    = '0;
        end

        if (ret_hit) begin
            wbusy_d[ret_w] = 1'b0;
            jdone_d        = jdone_q + (JW+1)'(1);
            if (cap) begin
                res_d     = res_slice[ret_w];
                res_job_d = job_of_q[ret_w];
                found_d   = 1'b1;
                rv_d      = 1'b1;
            end
        end

        if (go_ok) begin
            go_d[pick_w]     = 1'b1;
            wjob_d           = base_next[JW-1:0];
            wbusy_d[pick_w]  = 1'b1;
            job_of_d[pick_w] = base_next[JW-1:0];
            next_job_d       = base_next + (JW+1)'(1);
            rr_d             = KW'((int'(pick_w) + 1) % K);
        end

        case (state_q)
            S_IDLE:     if (start) state_d = S_DISPATCH;
            S_DISPATCH: begin
                if (STOP_ON_FOUND != 0 && (found_q || cap)) state_d = S_DRAIN;
                else if (next_job_q == (JW+1)'(JOBS))        state_d = S_DRAIN;
            end
            S_DRAIN:    if (wbusy_q == '0) state_d = S_FINISH;
            S_FINISH:   if (start) state_d = S_DISPATCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wbusy_q    <= '0;
            next_job_q <= '0;
            rr_q       <= '0;
            go_q       <= '0;
            wjob_q     <= '0;
            rv_q       <= 1'b0;
            res_q      <= '0;
            res_job_q  <= '0;
            found_q    <= 1'b0;
            jdone_q    <= '0;
            for (int w = 0; w < K; w++) job_of_q[w] <= '0;
        end else begin
            state_q    <= state_d;
            wbusy_q    <= wbusy_d;
            next_job_q <= next_job_d;
            rr_q       <= rr_d;
            go_q       <= go_d;
            wjob_q     <= wjob_d;
            rv_q       <= rv_d;
            res_q      <= res_d;
            res_job_q  <= res_job_d;
            found_q    <= found_d;
            jdone_q    <= jdone_d;
            job_of_q   <= job_of_d;
        end
    end

    assign busy      = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    assign done      = (state_q == S_FINISH);
    assign wk_go     = go_q;
    assign wk_job    = wjob_q;
    assign res_valid = rv_q;
    assign res       = res_q;
    assign res_job   = res_job_q;
    assign found     = found_q;
    assign jobs_done = jdone_q;

endmodule

// File: tb/tb_dts_search_scheduler.sv
// Directed bench for dts_search_scheduler: two instances (16 jobs and 2 jobs)
// driven by behavioural workers with per-worker latency and chosen found jobs.
module tb_dts_search_scheduler;
    localparam int N  = 3;
    localparam int M  = 19;
    localparam int K  = 4;
    localparam int KW = 2;
    localparam int JW = 4;
    localparam int RW = N * (M + 1);
    localparam logic [RW-1:0] RES_BASE = 60'h0ABCDEF01234500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, a_start, b_start;

    logic            a_busy, a_rv, a_found, a_done;
    logic [K-1:0]    a_go, a_wdone, a_wfound;
    logic [JW-1:0]   a_job, a_rjob;
    logic [K*RW-1:0] a_wres;
    logic [RW-1:0]   a_res;
    logic [JW:0]     a_jd;

    logic            b_busy, b_rv, b_found, b_done;
    logic [K-1:0]    b_go, b_wdone, b_wfound;
    logic [JW-1:0]   b_job, b_rjob;
    logic [K*RW-1:0] b_wres;
    logic [RW-1:0]   b_res;
    logic [JW:0]     b_jd;

    dts_search_scheduler #(.N(N), .M(M), .K(K), .KW(KW), .JOBS(16), .JW(JW), .STOP_ON_FOUND(1)) u_a (
        .clk(clk), .reset(rst_n), .start(a_start), .busy(a_busy), .wk_go(a_go), .wk_job(a_job),
        .wk_done(a_wdone), .wk_found(a_wfound), .wk_res(a_wres), .res_valid(a_rv), .res(a_res),
        .res_job(a_rjob), .found(a_found), .jobs_done(a_jd), .done(a_done));

    dts_search_scheduler #(.N(N), .M(M), .K(K), .KW(KW), .JOBS(2), .JW(JW), .STOP_ON_FOUND(1)) u_b (
        .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .wk_go(b_go), .wk_job(b_job),
        .wk_done(b_wdone), .wk_found(b_wfound), .wk_res(b_wres), .res_valid(b_rv), .res(b_res),
        .res_job(b_rjob), .found(b_found), .jobs_done(b_jd), .done(b_done));

    // Worker pool for instance A: done rises lat cycles after the go is seen.
    int            lat_a [K];
    int            fj0, fj1;
    int            cnt_a [K];
    logic [JW-1:0] wj_a [K];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wdone <= '0; a_wfound <= '0; a_wres <= '0;
            for (int w = 0; w < K; w++) begin cnt_a[w] <= 0; wj_a[w] <= '0; end
        end else begin
            for (int w = 0; w < K; w++) begin
                if (a_go[w]) begin
                    a_wdone[w] <= 1'b0; a_wfound[w] <= 1'b0;
                    cnt_a[w] <= lat_a[w]; wj_a[w] <= a_job;
                end else if (cnt_a[w] == 1) begin
                    cnt_a[w] <= 0;
                    a_wdone[w] <= 1'b1;
                    if (int'(wj_a[w]) == fj0 || int'(wj_a[w]) == fj1) begin
                        a_wfound[w] <= 1'b1;
                        a_wres[w*RW +: RW] <= RES_BASE | RW'(wj_a[w]);
                    end else begin
                        a_wfound[w] <= 1'b0;
                        a_wres[w*RW +: RW] <= '1;
                    end
                end else if (cnt_a[w] > 1) begin
                    cnt_a[w] <= cnt_a[w] - 1;
                end
            end
        end
    end

    int cnt_b [K];
    assign b_wfound = '0;
    assign b_wres   = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_wdone <= '0;
            for (int w = 0; w < K; w++) cnt_b[w] <= 0;
        end else begin
            for (int w = 0; w < K; w++) begin
                if (b_go[w]) begin b_wdone[w] <= 1'b0; cnt_b[w] <= 3; end
                else if (cnt_b[w] == 1) begin cnt_b[w] <= 0; b_wdone[w] <= 1'b1; end
                else if (cnt_b[w] > 1) cnt_b[w] <= cnt_b[w] - 1;
            end
        end
    end

    // Monitors: running totals only; the main sequence works with deltas.
    int a_gocnt [16];
    int a_gos = 0, a_dbl = 0, a_late = 0, a_rvcnt = 0, b_gos = 0;
    logic [K-1:0] a_out;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_out = '0;
        end else begin
            if (a_go != '0) begin
                a_gos++;
                a_gocnt[a_job]++;
                if (!$onehot(a_go)) a_dbl++;
                if (a_found || a_rv) a_late++;
            end
            for (int w = 0; w < K; w++) begin
                if (a_go[w]) begin
                    if (a_out[w]) a_dbl++;
                    a_out[w] = 1'b1;
                end else if (a_wdone[w]) begin
                    a_out[w] = 1'b0;
                end
            end
            if (a_rv) a_rvcnt++;
            if (b_go != '0) b_gos++;
        end
    end

    int n_chk = 0, n_fail = 0;
    int snap [16];
    int s_gos, s_dbl, s_late, s_rv, s_bgos;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap_all();
        for (int j = 0; j < 16; j++) snap[j] = a_gocnt[j];
        s_gos = a_gos; s_dbl = a_dbl; s_late = a_late; s_rv = a_rvcnt; s_bgos = b_gos;
    endtask

    function automatic logic [15:0] once_mask();
        logic [15:0] m;
        for (int j = 0; j < 16; j++) m[j] = ((a_gocnt[j] - snap[j]) == 1);
        return m;
    endfunction

    task automatic start_a();
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int c = 0;
        while (!a_done && c < 400) begin tick(1); c++; end
        check_eq(tag, a_done, 1);
    endtask

    task automatic wait_done_b(input string tag);
        int c = 0;
        while (!b_done && c < 100) begin tick(1); c++; end
        check_eq(tag, b_done, 1);
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat_a[0] = l0; lat_a[1] = l1; lat_a[2] = l2; lat_a[3] = l3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        fj0 = -1; fj1 = -1;
        set_lat(5, 5, 5, 5);
        for (int j = 0; j < 16; j++) a_gocnt[j] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_go", a_go, 0);
        check_eq("rst_jd", a_jd, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_found", a_found, 0);
        check_eq("rst_res", a_res, 0);
        @(negedge clk) rst_n = 1'b1;

        // Plain run, no result found; a stray start mid-run must be ignored.
        snap_all();
        start_a();
        check_eq("s1_go0", a_go, 4'b0001);
        check_eq("s1_job0", a_job, 0);
        check_eq("s1_busy", a_busy, 1);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check_eq("s1_go_rr", a_go, 4'b0001 << i);
            check_eq("s1_job_rr", a_job, i);
        end
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        wait_done_a("s1_done");
        check_eq("s1_jd", a_jd, 16);
        check_eq("s1_found", a_found, 0);
        check_eq("s1_res", a_res, 0);
        check_eq("s1_gos", a_gos - s_gos, 16);
        check_eq("s1_once", once_mask(), 16'hFFFF);
        check_eq("s1_dbl", a_dbl - s_dbl, 0);
        check_eq("s1_rv", a_rvcnt - s_rv, 0);
        check_eq("s1_busy_end", a_busy, 0);

        // Worker 2 finds on job 6: capture, stop dispatching, drain 7 and 8.
        fj0 = 6;
        snap_all();
        start_a();
        check_eq("s2_jd_clr", a_jd, 0);
        check_eq("s2_done_clr", a_done, 0);
        check_eq("s2_go0", a_go, 4'b0001);
        wait_done_a("s2_done");
        check_eq("s2_found", a_found, 1);
        check_eq("s2_rjob", a_rjob, 6);
        check_eq("s2_res", a_res, RES_BASE | 60'd6);
        check_eq("s2_rv", a_rvcnt - s_rv, 1);
        check_eq("s2_late", a_late - s_late, 0);
        check_eq("s2_jd", a_jd, 9);
        check_eq("s2_gos", a_gos - s_gos, 9);
        check_eq("s2_once", once_mask(), 16'h01FF);

        // Workers 1 and 3 find in the same cycle: lower index wins.
        set_lat(10, 5, 10, 3);
        fj0 = 1; fj1 = 3;
        snap_all();
        start_a();
        check_eq("s3_found_clr", a_found, 0);
        tick(7);
        check_eq("s3_jd_pre", a_jd, 0);
        check_eq("s3_rv_pre", a_rv, 0);
        tick(1);
        check_eq("s3_rv", a_rv, 1);
        check_eq("s3_rjob", a_rjob, 1);
        check_eq("s3_res", a_res, RES_BASE | 60'd1);
        check_eq("s3_jd1", a_jd, 1);
        tick(1);
        check_eq("s3_rv_off", a_rv, 0);
        check_eq("s3_jd2", a_jd, 2);
        check_eq("s3_rjob_hold", a_rjob, 1);
        check_eq("s3_res_hold", a_res, RES_BASE | 60'd1);
        wait_done_a("s3_done");
        check_eq("s3_jd", a_jd, 4);
        check_eq("s3_gos", a_gos - s_gos, 4);
        check_eq("s3_rvcnt", a_rvcnt - s_rv, 1);

        // Worker 0 retires when rr points at it: no go that cycle, go next.
        set_lat(4, 10, 10, 10);
        fj0 = -1; fj1 = -1;
        snap_all();
        start_a();
        tick(6);
        check_eq("s4_go_ret", a_go, 0);
        check_eq("s4_jd_ret", a_jd, 1);
        tick(1);
        check_eq("s4_go_w0", a_go, 4'b0001);
        check_eq("s4_job4", a_job, 4);
        tick(1);
        check_eq("s4_go_after", a_go, 0);
        check_eq("s4_jd_stale", a_jd, 1);
        wait_done_a("s4_done");
        check_eq("s4_jd", a_jd, 16);
        check_eq("s4_once", once_mask(), 16'hFFFF);
        check_eq("s4_dbl", a_dbl - s_dbl, 0);

        // Fewer jobs than workers, then a restart from FINISH.
        snap_all();
        start_b();
        check_eq("s5_go0", b_go, 4'b0001);
        check_eq("s5_job0", b_job, 0);
        tick(1);
        check_eq("s5_go1", b_go, 4'b0010);
        check_eq("s5_job1", b_job, 1);
        tick(1);
        check_eq("s5_go_none", b_go, 0);
        check_eq("s5_job_none", b_job, 0);
        wait_done_b("s5_done");
        check_eq("s5_jd", b_jd, 2);
        check_eq("s5_gos", b_gos - s_bgos, 2);
        start_b();
        check_eq("s5_re_jd", b_jd, 0);
        check_eq("s5_re_found", b_found, 0);
        check_eq("s5_re_done", b_done, 0);
        check_eq("s5_re_go", b_go, 4'b0001);
        wait_done_b("s5_re_fin");
        check_eq("s5_re_jdend", b_jd, 2);
        check_eq("s5_re_gos", b_gos - s_bgos, 4);

        // Asynchronous reset in the middle of dispatch.
        set_lat(20, 20, 20, 20);
        start_a();
        tick(2);
        check_eq("s6_go_pre", a_go, 4'b0100);
        rst_n = 1'b0;
        #1;
        check_eq("s6_go_rst", a_go, 0);
        check_eq("s6_job_rst", a_job, 0);
        check_eq("s6_busy_rst", a_busy, 0);
        check_eq("s6_jd_rst", a_jd, 0);
        check_eq("s6_done_rst", a_done, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        start_a();
        check_eq("s6_go0", a_go, 4'b0001);
        check_eq("s6_job0", a_job, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
